// File: rtl/reflex_round_controller.sv
// -----------------------------------------------------------------------------
// reflex_round_controller
//
// Sequences one Reflex-Trainer game. After start it alternates between a
// random hold-off (WAIT) and a lit target (TARGET). Reaction time is measured
// in milliseconds, and hits and misses are counted. The game ends after ROUNDS
// rounds or once the external game-second timer reaches GAME_SECONDS,
// whichever comes first.
//
// Parameters
//   MS_DIV       clk cycles per 1 ms tick
//   ROUNDS       rounds per game (1..15)
//   TIMEOUT_MS   max ms the target stays lit before it counts as a miss (<=1023)
//   MIN_WAIT_MS  fixed part of the random hold-off
//   GAME_SECONDS game-time limit, compared to elapsed_time (<=31)
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   start         in   1-cycle pulse, debounced start button
//   hit           in   1-cycle pulse, debounced player button
//   elapsed_time  in   [4:0] game seconds from the game timer
//   game_run      out  run/enable level to the game timer (WAIT and TARGET)
//   target_on     out  target LED, high only in TARGET
//   round         out  [3:0] rounds completed in this game
//   score         out  [3:0] hits in this game
//   last_rt_ms    out  [9:0] latest valid reaction time in ms
//   rt_valid      out  1-cycle pulse, last_rt_ms updated
//   miss          out  1-cycle pulse, early press or timeout
//   done          out  high in DONE
// -----------------------------------------------------------------------------
module reflex_round_controller #(
   parameter int unsigned MS_DIV       = 100000,
   parameter int unsigned ROUNDS       = 8,
   parameter int unsigned TIMEOUT_MS   = 1000,
   parameter int unsigned MIN_WAIT_MS  = 500,
   parameter int unsigned GAME_SECONDS = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       hit,
   input  logic [4:0] elapsed_time,
   output logic       game_run,
   output logic       target_on,
   output logic [3:0] round,
   output logic [3:0] score,
   output logic [9:0] last_rt_ms,
   output logic       rt_valid,
   output logic       miss,
   output logic       done
);

   localparam int unsigned PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StTarget, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [10:0] ms_cnt_q, ms_cnt_d;
   logic [10:0] delay_q, delay_d;
   logic [9:0]  rt_cnt_q, rt_cnt_d;
   logic [3:0]  round_q, round_d;
   logic [3:0]  score_q, score_d;
   logic [9:0]  last_rt_q, last_rt_d;
   logic        rt_valid_q, rt_valid_d;
   logic        miss_q, miss_d;

   logic        ms_tick;
   logic [10:0] new_delay;
   logic [3:0]  round_inc;
   logic        game_over;
   logic        time_up;
   logic        timeout;

   // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
   assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   assign ms_tick   = (presc_q == PW'(MS_DIV - 1));
   assign new_delay = 11'(MIN_WAIT_MS) + {1'b0, lfsr_q[9:0]};
   assign round_inc = round_q + 4'd1;
   assign time_up   = (elapsed_time >= 5'(GAME_SECONDS));
   // A round that completes now either ends the game or returns to WAIT
   assign game_over = (round_inc == 4'(ROUNDS)) || time_up;
   assign timeout   = ms_tick && (rt_cnt_q == 10'(TIMEOUT_MS - 1));

   always_comb begin
      state_d    = state_q;
      presc_d    = ms_tick ? '0 : presc_q + 1'b1;
      ms_cnt_d   = ms_cnt_q;
      delay_d    = delay_q;
      rt_cnt_d   = rt_cnt_q;
      round_d    = round_q;
      score_d    = score_q;
      last_rt_d  = last_rt_q;
      rt_valid_d = 1'b0;
      miss_d     = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d  = StWait;
               round_d  = '0;
               score_d  = '0;
               delay_d  = new_delay;
               ms_cnt_d = '0;
            end
         end

         StWait: begin
            if (hit) begin
               // Early press: miss, and the hold-off restarts with a fresh delay
               miss_d   = 1'b1;
               round_d  = round_inc;
               delay_d  = new_delay;
               ms_cnt_d = '0;
               presc_d  = '0;
               if (game_over) state_d = StDone;
            end else if (time_up) begin
               state_d = StDone;
            end else if (ms_tick) begin
               if (ms_cnt_q + 11'd1 == delay_q) begin
                  state_d  = StTarget;
                  rt_cnt_d = '0;
               end else begin
                  ms_cnt_d = ms_cnt_q + 11'd1;
               end
            end
         end

         StTarget: begin
            // A hit wins over a timeout tick in the same cycle
            if (hit || timeout) begin
               if (hit) begin
                  rt_valid_d = 1'b1;
                  last_rt_d  = rt_cnt_q;
                  score_d    = score_q + 4'd1;
               end else begin
                  miss_d = 1'b1;
               end
               round_d  = round_inc;
               delay_d  = new_delay;
               ms_cnt_d = '0;
               state_d  = game_over ? StDone : StWait;
            end else if (time_up) begin
               state_d = StDone;
            end else if (ms_tick && (rt_cnt_q != '1)) begin
               rt_cnt_d = rt_cnt_q + 10'd1;
            end
         end

         default: state_d = StIdle;
      endcase

      // Every state entry starts a full-length millisecond
      if (state_d != state_q) presc_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         lfsr_q     <= 16'hACE1;
         presc_q    <= '0;
         ms_cnt_q   <= '0;
         delay_q    <= '0;
         rt_cnt_q   <= '0;
         round_q    <= '0;
         score_q    <= '0;
         last_rt_q  <= '0;
         rt_valid_q <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         presc_q    <= presc_d;
         ms_cnt_q   <= ms_cnt_d;
         delay_q    <= delay_d;
         rt_cnt_q   <= rt_cnt_d;
         round_q    <= round_d;
         score_q    <= score_d;
         last_rt_q  <= last_rt_d;
         rt_valid_q <= rt_valid_d;
         miss_q     <= miss_d;
      end
   end

   assign game_run   = (state_q == StWait) || (state_q == StTarget);
   assign target_on  = (state_q == StTarget);
   assign done       = (state_q == StDone);
   assign round      = round_q;
   assign score      = score_q;
   assign last_rt_ms = last_rt_q;
   assign rt_valid   = rt_valid_q;
   assign miss       = miss_q;

endmodule
